// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths and scoreboard slot layout for the operand fetch stage
//   GPR_COUNT/GPR_AW/DATA_W : register file geometry
//   CNT_W                   : per-register pending-write counter width
//   SB_N/SB_HI/SB_LO        : scoreboard slots (GPR 0..31, then HI, then LO)
package operand_fetch_pkg;
    localparam int GPR_COUNT = 32;
    localparam int GPR_AW    = 5;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 2;
    localparam int SB_N      = GPR_COUNT + 2;
    localparam int SB_HI     = GPR_COUNT;
    localparam int SB_LO     = GPR_COUNT + 1;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: pending-write counters for GPRs, HI and LO
//   clk, rst           : clock, synchronous active-low reset
//   i_inc, i_dec       : per-slot issue / retire strobes
//   i_rs, i_rt, i_dest : GPR numbers to look up
//   o_*_cnt            : combinational pending counts for the looked-up slots
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SB_N-1:0]   i_inc,
    input  logic [SB_N-1:0]   i_dec,
    input  logic [GPR_AW-1:0] i_rs,
    input  logic [GPR_AW-1:0] i_rt,
    input  logic [GPR_AW-1:0] i_dest,
    output logic [CNT_W-1:0]  o_rs_cnt,
    output logic [CNT_W-1:0]  o_rt_cnt,
    output logic [CNT_W-1:0]  o_dest_cnt,
    output logic [CNT_W-1:0]  o_hi_cnt,
    output logic [CNT_W-1:0]  o_lo_cnt
);
    logic [CNT_W-1:0] r_cnt [SB_N];

    // Simultaneous issue and retire cancel; a retire on an empty counter is dropped.
    always_ff @(posedge clk) begin
        for (int k = 0; k < SB_N; k++)
            if (!rst)
                r_cnt[k] <= '0;
            else if (i_inc[k] && !i_dec[k])
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            else if (i_dec[k] && !i_inc[k] && r_cnt[k] != '0)
                r_cnt[k] <= r_cnt[k] - CNT_W'(1);
    end

    assign o_rs_cnt   = r_cnt[{1'b0, i_rs}];
    assign o_rt_cnt   = r_cnt[{1'b0, i_rt}];
    assign o_dest_cnt = r_cnt[{1'b0, i_dest}];
    assign o_hi_cnt   = r_cnt[SB_HI];
    assign o_lo_cnt   = r_cnt[SB_LO];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-side operand read with scoreboard hazards, writeback bypass and output register
//   clk, rst                 : clock, synchronous active-low reset
//   id_*                     : instruction offered by decode, id_ready accepts it
//   rs, rt                   : register file read addresses (combinational)
//   rs/rt/hi/lo_value        : register file and HI/LO read data
//   write_*                  : writeback retire strobes, address and data
//   of_*, ex_ready           : registered operand bundle to execute, valid/ready
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [GPR_AW-1:0] id_rs,
    input  logic [GPR_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_hi,
    input  logic              id_use_lo,
    input  logic              id_dest_we,
    input  logic [GPR_AW-1:0] id_dest,
    input  logic              id_write_hi,
    input  logic              id_write_lo,
    output logic [GPR_AW-1:0] rs,
    output logic [GPR_AW-1:0] rt,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    input  logic [DATA_W-1:0] hi_value,
    input  logic [DATA_W-1:0] lo_value,
    input  logic              write_reg,
    input  logic              write_hi,
    input  logic              write_lo,
    input  logic [GPR_AW-1:0] write_reg_address,
    input  logic [DATA_W-1:0] write_reg_value,
    input  logic [DATA_W-1:0] write_hi_value,
    input  logic [DATA_W-1:0] write_lo_value,
    output logic              of_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] of_rs_value,
    output logic [DATA_W-1:0] of_rt_value,
    output logic [DATA_W-1:0] of_hi_value,
    output logic [DATA_W-1:0] of_lo_value,
    output logic              of_dest_we,
    output logic              of_write_hi,
    output logic              of_write_lo,
    output logic [GPR_AW-1:0] of_dest
);
    logic [CNT_W-1:0] w_rs_cnt, w_rt_cnt, w_dest_cnt, w_hi_cnt, w_lo_cnt;
    logic [SB_N-1:0]  w_inc, w_dec;
    logic             w_rs_wb, w_rt_wb, w_rs_haz, w_rt_haz, w_hi_haz, w_lo_haz;
    logic             w_struct_haz, w_issue;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_hi_val, w_lo_val;

    assign rs = id_rs;
    assign rt = id_rt;

    // Same-cycle writeback of the last pending write resolves the hazard via bypass.
    assign w_rs_wb  = write_reg && write_reg_address == id_rs;
    assign w_rt_wb  = write_reg && write_reg_address == id_rt;
    assign w_rs_haz = id_use_rs && id_rs != '0 && (w_rs_cnt > 2'd1 || (w_rs_cnt == 2'd1 && !w_rs_wb));
    assign w_rt_haz = id_use_rt && id_rt != '0 && (w_rt_cnt > 2'd1 || (w_rt_cnt == 2'd1 && !w_rt_wb));
    assign w_hi_haz = id_use_hi && (w_hi_cnt > 2'd1 || (w_hi_cnt == 2'd1 && !write_hi));
    assign w_lo_haz = id_use_lo && (w_lo_cnt > 2'd1 || (w_lo_cnt == 2'd1 && !write_lo));

    assign w_struct_haz = (id_dest_we && id_dest != '0 && w_dest_cnt == CNT_W'(MAX_INFLIGHT))
                       || (id_write_hi && w_hi_cnt == CNT_W'(MAX_INFLIGHT))
                       || (id_write_lo && w_lo_cnt == CNT_W'(MAX_INFLIGHT));

    assign id_ready = !(w_rs_haz || w_rt_haz || w_hi_haz || w_lo_haz || w_struct_haz)
                   && (!of_valid || ex_ready);
    assign w_issue  = id_valid && id_ready;

    // GPR 0 is never tracked, so its slot never counts.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_inc[{1'b0, id_dest}] = w_issue && id_dest_we && id_dest != '0;
        w_inc[SB_HI] = w_issue && id_write_hi;
        w_inc[SB_LO] = w_issue && id_write_lo;
        w_dec[{1'b0, write_reg_address}] = write_reg && write_reg_address != '0;
        w_dec[SB_HI] = write_hi;
        w_dec[SB_LO] = write_lo;
    end

    operand_fetch_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .i_rs       (id_rs),
        .i_rt       (id_rt),
        .i_dest     (id_dest),
        .o_rs_cnt   (w_rs_cnt),
        .o_rt_cnt   (w_rt_cnt),
        .o_dest_cnt (w_dest_cnt),
        .o_hi_cnt   (w_hi_cnt),
        .o_lo_cnt   (w_lo_cnt)
    );

    assign w_rs_val = id_rs == '0 ? '0 : w_rs_wb ? write_reg_value : rs_value;
    assign w_rt_val = id_rt == '0 ? '0 : w_rt_wb ? write_reg_value : rt_value;
    assign w_hi_val = write_hi ? write_hi_value : hi_value;
    assign w_lo_val = write_lo ? write_lo_value : lo_value;

    always_ff @(posedge clk) begin
        if (!rst) begin
            of_valid    <= 1'b0;
            of_rs_value <= '0;
            of_rt_value <= '0;
            of_hi_value <= '0;
            of_lo_value <= '0;
            of_dest_we  <= 1'b0;
            of_write_hi <= 1'b0;
            of_write_lo <= 1'b0;
            of_dest     <= '0;
        end else if (w_issue) begin
            of_valid    <= 1'b1;
            of_rs_value <= w_rs_val;
            of_rt_value <= w_rt_val;
            of_hi_value <= w_hi_val;
            of_lo_value <= w_lo_val;
            of_dest_we  <= id_dest_we;
            of_write_hi <= id_write_hi;
            of_write_lo <= id_write_lo;
            of_dest     <= id_dest;
        end else if (ex_ready) begin
            of_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against a count-based reference model
module tb_operand_fetch;
    logic clk = 1'b0, rst;
    logic id_valid, id_ready, id_use_rs, id_use_rt, id_use_hi, id_use_lo;
    logic id_dest_we, id_write_hi, id_write_lo;
    logic [4:0] id_rs, id_rt, id_dest, rs, rt, write_reg_address, of_dest;
    logic [31:0] rs_value, rt_value, hi_value, lo_value;
    logic write_reg, write_hi, write_lo;
    logic [31:0] write_reg_value, write_hi_value, write_lo_value;
    logic of_valid, ex_ready, of_dest_we, of_write_hi, of_write_lo;
    logic [31:0] of_rs_value, of_rt_value, of_hi_value, of_lo_value;

    int checks = 0, failures = 0;

    int m_cnt [34];
    logic m_valid, m_dwe, m_whi, m_wlo;
    logic [4:0] m_dest;
    logic [31:0] m_rs, m_rt, m_hi, m_lo;

    operand_fetch dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_use_hi(id_use_hi), .id_use_lo(id_use_lo), .id_dest_we(id_dest_we),
        .id_dest(id_dest), .id_write_hi(id_write_hi), .id_write_lo(id_write_lo),
        .rs(rs), .rt(rt), .rs_value(rs_value), .rt_value(rt_value),
        .hi_value(hi_value), .lo_value(lo_value), .write_reg(write_reg),
        .write_hi(write_hi), .write_lo(write_lo), .write_reg_address(write_reg_address),
        .write_reg_value(write_reg_value), .write_hi_value(write_hi_value),
        .write_lo_value(write_lo_value), .of_valid(of_valid), .ex_ready(ex_ready),
        .of_rs_value(of_rs_value), .of_rt_value(of_rt_value), .of_hi_value(of_hi_value),
        .of_lo_value(of_lo_value), .of_dest_we(of_dest_we), .of_write_hi(of_write_hi),
        .of_write_lo(of_write_lo), .of_dest(of_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b1; id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_use_hi = 0; id_use_lo = 0;
        id_dest_we = 0; id_write_hi = 0; id_write_lo = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        write_reg = 0; write_hi = 0; write_lo = 0; write_reg_address = 0;
        write_reg_value = 0; write_hi_value = 0; write_lo_value = 0;
        rs_value = 0; rt_value = 0; hi_value = 0; lo_value = 0; ex_ready = 1;
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_valid = 0; m_dwe = 0; m_whi = 0; m_wlo = 0; m_dest = 0;
        m_rs = 0; m_rt = 0; m_hi = 0; m_lo = 0;
    endtask

    // Source x is blocked when more than one write is pending, or exactly one that is not retiring now.
    function automatic bit src_blocked(input bit used, input int x, input bit retiring);
        return used && x != 0 && (m_cnt[x] > 1 || (m_cnt[x] == 1 && !retiring));
    endfunction

    // One clock: check combinational outputs against the model, advance the model, check registered outputs.
    task automatic cycle();
        bit haz, exp_ready, issue;
        int nc [34];
        int d, wa;
        logic nv;
        logic [31:0] nrs, nrt, nhi, nlo;
        #1;
        d = int'(id_dest);
        wa = int'(write_reg_address);
        haz = src_blocked(id_use_rs, int'(id_rs), write_reg && wa == int'(id_rs))
           || src_blocked(id_use_rt, int'(id_rt), write_reg && wa == int'(id_rt))
           || src_blocked(id_use_hi, 32, write_hi)
           || src_blocked(id_use_lo, 33, write_lo)
           || (id_dest_we && d != 0 && m_cnt[d] == 3)
           || (id_write_hi && m_cnt[32] == 3)
           || (id_write_lo && m_cnt[33] == 3);
        exp_ready = !haz && (!m_valid || ex_ready);
        chk("id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
        chk("rs_addr", {27'b0, rs}, {27'b0, id_rs});
        chk("rt_addr", {27'b0, rt}, {27'b0, id_rt});
        issue = id_valid && exp_ready;
        foreach (nc[i]) begin
            nc[i] = m_cnt[i];
            if (issue && ((i == d && id_dest_we && i != 0) || (i == 32 && id_write_hi) || (i == 33 && id_write_lo)))
                nc[i]++;
            if ((i == wa && write_reg && i != 0) || (i == 32 && write_hi) || (i == 33 && write_lo))
                nc[i]--;
            if (nc[i] < 0) nc[i] = 0;
        end
        nv = issue ? 1'b1 : ex_ready ? 1'b0 : m_valid;
        nrs = id_rs == 0 ? 32'h0 : (write_reg && wa == int'(id_rs)) ? write_reg_value : rs_value;
        nrt = id_rt == 0 ? 32'h0 : (write_reg && wa == int'(id_rt)) ? write_reg_value : rt_value;
        nhi = write_hi ? write_hi_value : hi_value;
        nlo = write_lo ? write_lo_value : lo_value;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            m_cnt = nc;
            m_valid = nv;
            if (issue) begin
                m_rs = nrs; m_rt = nrt; m_hi = nhi; m_lo = nlo;
                m_dwe = id_dest_we; m_whi = id_write_hi; m_wlo = id_write_lo; m_dest = id_dest;
            end
        end
        #1;
        chk("of_valid", {31'b0, of_valid}, {31'b0, m_valid});
        chk("of_rs_value", of_rs_value, m_rs);
        chk("of_rt_value", of_rt_value, m_rt);
        chk("of_hi_value", of_hi_value, m_hi);
        chk("of_lo_value", of_lo_value, m_lo);
        chk("of_ctrl", {27'b0, of_dest_we, of_write_hi, of_write_lo, of_dest[1:0]},
            {27'b0, m_dwe, m_whi, m_wlo, m_dest[1:0]});
        chk("of_dest", {27'b0, of_dest}, {27'b0, m_dest});
    endtask

    initial begin
        int cands[$];
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_of_valid", {31'b0, of_valid}, 32'h0);
        chk("reset_of_rs", of_rs_value, 32'h0);
        chk("reset_of_ctrl", {29'b0, of_dest_we, of_write_hi, of_write_lo}, 32'h0);
        idle();

        // addu r5, r3, r4
        id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_rs = 3; id_rt = 4;
        id_dest_we = 1; id_dest = 5; rs_value = 32'h11; rt_value = 32'h22;
        cycle();
        chk("addu_valid", {31'b0, of_valid}, 32'h1);
        chk("addu_rs", of_rs_value, 32'h11);
        chk("addu_rt", of_rt_value, 32'h22);

        // reader of r5 while r5 retires: bypass, no stall
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = 5; rs_value = 32'h55;
        write_reg = 1; write_reg_address = 5; write_reg_value = 32'hDEAD;
        #1 chk("bypass_ready", {31'b0, id_ready}, 32'h1);
        cycle();
        chk("bypass_rs", of_rs_value, 32'hDEAD);
        idle();
        id_valid = 1; id_dest_we = 1; id_dest = 5;
        #1 chk("r5_drained_ready", {31'b0, id_ready}, 32'h1);
        cycle();
        idle();
        write_reg = 1; write_reg_address = 5; write_reg_value = 32'h1;
        cycle();

        // writer r7, then reader stalls until r7 retires
        idle();
        id_valid = 1; id_dest_we = 1; id_dest = 7;
        cycle();
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = 7; rs_value = 32'h700;
        for (int i = 0; i < 3; i++) begin
            #1 chk("r7_stall", {31'b0, id_ready}, 32'h0);
            cycle();
        end
        write_reg = 1; write_reg_address = 7; write_reg_value = 32'h77;
        #1 chk("r7_resolve", {31'b0, id_ready}, 32'h1);
        cycle();
        chk("r7_value", of_rs_value, 32'h77);

        // three writers of r9, fourth stalls on the full counter
        idle();
        id_valid = 1; id_dest_we = 1; id_dest = 9;
        repeat (3) cycle();
        #1 chk("r9_full", {31'b0, id_ready}, 32'h0);
        cycle();
        write_reg = 1; write_reg_address = 9; write_reg_value = 32'h9;
        cycle();
        write_reg = 0;
        #1 chk("r9_after_retire", {31'b0, id_ready}, 32'h1);
        cycle();
        #1 chk("r9_full_again", {31'b0, id_ready}, 32'h0);

        // r0 always reads 0; back-pressure holds the bundle
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = 0; rs_value = 32'h1234;
        write_reg = 1; write_reg_address = 0; write_reg_value = 32'hBAD;
        cycle();
        chk("r0_value", of_rs_value, 32'h0);
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = 1; rs_value = 32'hAAAA; ex_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("hold_ready", {31'b0, id_ready}, 32'h0);
            cycle();
            chk("hold_valid", {31'b0, of_valid}, 32'h1);
            chk("hold_rs", of_rs_value, 32'h0);
        end

        // reset mid-stall with r12 doubly pending
        idle();
        id_valid = 1; id_dest_we = 1; id_dest = 12;
        repeat (2) cycle();
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = 12;
        #1 chk("r12_stall", {31'b0, id_ready}, 32'h0);
        cycle();
        rst = 0; write_reg = 1; write_reg_address = 12; write_reg_value = 32'hC;
        cycle();
        chk("rst_of_valid", {31'b0, of_valid}, 32'h0);
        rst = 1; write_reg = 0;
        #1 chk("rst_cleared_r12", {31'b0, id_ready}, 32'h1);
        cycle();
        chk("rst_reissue_valid", {31'b0, of_valid}, 32'h1);

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = $urandom_range(0, 299) != 0;
            id_valid = $urandom_range(0, 3) != 0;
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
            id_dest = 5'($urandom_range(0, 7));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_use_hi = $urandom_range(0, 3) == 0; id_use_lo = $urandom_range(0, 3) == 0;
            id_dest_we = 1'($urandom);
            id_write_hi = $urandom_range(0, 3) == 0; id_write_lo = $urandom_range(0, 3) == 0;
            rs_value = $urandom; rt_value = $urandom; hi_value = $urandom; lo_value = $urandom;
            ex_ready = $urandom_range(0, 3) != 0;
            cands.delete();
            for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) cands.push_back(i);
            if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                write_reg = 1;
                write_reg_address = 5'(cands[$urandom_range(0, cands.size() - 1)]);
                write_reg_value = $urandom;
            end
            write_hi = m_cnt[32] > 0 && $urandom_range(0, 1) == 1;
            write_lo = m_cnt[33] > 0 && $urandom_range(0, 1) == 1;
            write_hi_value = $urandom; write_lo_value = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
